keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad: drives one column low at a time, samples the
//  rows, debounces a single press and emits a one-cycle strobe plus a 4-bit
//  hex code. Sits upstream of the lock FSM / SSD path and feeds its key-value
//  and key-pressed inputs. One key is accepted per press; a new key needs a release.
// PARAMETERS
//  CLK_FREQ     50_000_000  clk frequency in Hz
//  SCAN_HZ      1_000       column dwell rate; DWELL = CLK_FREQ/SCAN_HZ cycles per column
//  DEBOUNCE_MS  10          stable time; DB = CLK_FREQ/1000*DEBOUNCE_MS cycles
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  row        in   4  keypad rows, active-low (pulled up externally), asynchronous
//  col        out  4  keypad column drive, active-low one-hot
//  key_value  out  4  hex code of last accepted key, held until next accept
//  key_valid  out  1  one-cycle strobe when key_value is updated
//  key_held   out  1  high from accept until release debounce completes
// BEHAVIOUR
//  - Reset (next edge with rst=1, also mid-operation): state SCAN, column index 0,
//    col=4'b1110, key_value=0, key_valid=0, key_held=0, all counters 0.
//  - row goes through a 2-FF synchroniser; all decisions use synced rows (rs).
//  - Key map (col index c, row index r): c0: r0..r3 = 1,4,7,0; c1: 2,5,8,F;
//    c2: 3,6,9,E; c3: A,B,C,D.
//  - SCAN: col drives column c low for DWELL cycles; rs sampled on the last
//    dwell cycle only (settle time). Exactly one row low -> latch c, r, pattern,
//    go DEBOUNCE with col frozen. Zero or >1 rows low -> c=(c+1) mod 4, wrap 3->0.
//  - DEBOUNCE: counter counts cycles while rs equals latched pattern; any
//    mismatch -> clear counter, c=(c+1) mod 4, back to SCAN. When count reaches
//    DB-1: next cycle key_value=map(c,r), key_valid=1 for exactly that cycle,
//    key_held=1, go HOLD.
//  - HOLD: col stays frozen; remains while any rs bit low; all rows high -> RELEASE.
//    Other keys pressed meanwhile are ignored.
//  - RELEASE: counts cycles with rs==4'b1111; any low row -> back to HOLD,
//    counter cleared. Count reaches DB-1 -> key_held=0, c=0, SCAN.
//  - key_valid never high for two consecutive cycles; never high outside the
//    DEBOUNCE->HOLD transition. key_value changes only with key_valid.
//  - Latency: press stable from sample point -> key_valid after DB+1 cycles
//    (+2 synchroniser cycles from pin).
//  - Counters sized $clog2 of max(DWELL,DB)+1; no overflow possible.
// TESTING (CLK_FREQ=100_000, SCAN_HZ=1_000, DEBOUNCE_MS=10: DWELL=100, DB=1000)
//  1. Reset then idle rows=4'hF -> col cycles 1110,1101,1011,0111,1110 each 100
//     cycles; key_valid stays 0.
//  2. Model holds row1 low when col=1101 for 2000 cycles -> exactly one key_valid
//     pulse, key_value=4'h5, key_held=1 until 1000 cycles after release.
//  3. Press '9' (c2,r2) bouncing every 50 cycles for 400 cycles then stable ->
//     single key_valid, key_value=4'h9, no pulse during bounce.
//  4. Rows r0 and r1 both low on column 0 -> no key_valid, scanning continues.
//  5. Hold 'A', press 'D' during HOLD, release 'A' keeping 'D' -> no second
//     pulse until 'D' released 1000 cycles then re-pressed -> key_value=4'hD.
//  6. Assert rst during DEBOUNCE and during HOLD -> next edge col=1110,
//     key_held=0, key_valid=0, key_value=0.

Source files
------------

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time. A single pressed
// key is debounced, reported once with a one-cycle key_valid strobe and a hex
// code, and then held until every row reads high for a full debounce window.
module keypad_scanner #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int SCAN_HZ     = 1_000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_held
);

  // Column dwell and debounce windows in clock cycles.
  localparam int DWELL   = CLK_FREQ / SCAN_HZ;
  localparam int DB      = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int CNT_MAX = (DWELL > DB) ? DWELL : DB;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    pattern_q, pattern_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_value_q, key_value_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  // Two-stage synchroniser for the asynchronous row inputs.
  logic [3:0]    row_meta_q;
  logic [3:0]    row_sync_q;

  // One flag per row: set when that row alone is pulled low.
  logic [3:0]    row_hit;
  logic          single_low;
  logic [1:0]    row_idx_enc;

  // Map (column, row) to the hex legend printed on the keypad.
  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] code;
    code = 4'h0;
    case ({c, r})
      4'h0: code = 4'h1;
      4'h1: code = 4'h4;
      4'h2: code = 4'h7;
      4'h3: code = 4'h0;
      4'h4: code = 4'h2;
      4'h5: code = 4'h5;
      4'h6: code = 4'h8;
      4'h7: code = 4'hF;
      4'h8: code = 4'h3;
      4'h9: code = 4'h6;
      4'hA: code = 4'h9;
      4'hB: code = 4'hE;
      4'hC: code = 4'hA;
      4'hD: code = 4'hB;
      4'hE: code = 4'hC;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Exact single-low patterns; a chord of two or more rows matches none of them.
  for (genvar gi = 0; gi < 4; gi++) begin : g_row_hit
    assign row_hit[gi] = (row_sync_q == ~(4'b0001 << gi));
  end

  assign single_low = |row_hit;

  // Encode the low row index; only meaningful when single_low is set.
  always_comb begin
    row_idx_enc = 2'd0;
    case (row_hit)
      4'b0001: row_idx_enc = 2'd0;
      4'b0010: row_idx_enc = 2'd1;
      4'b0100: row_idx_enc = 2'd2;
      4'b1000: row_idx_enc = 2'd3;
      default: row_idx_enc = 2'd0;
    endcase
  end

  // Active-low one-hot column drive derived from the current column index.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col_drive
    assign col[gi] = (col_idx_q != 2'(gi));
  end

  // Resynchronise rows; idle (all high) is the reset value since rows are pulled up.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      pattern_q   <= 4'hF;
      cnt_q       <= '0;
      key_value_q <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      pattern_q   <= pattern_d;
      cnt_q       <= cnt_d;
      key_value_q <= key_value_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state logic: scan, debounce press, hold, debounce release.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    pattern_d   = pattern_q;
    cnt_d       = cnt_q;
    key_value_d = key_value_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    unique case (state_q)
      ST_SCAN: begin
        // Rows are only trusted on the last dwell cycle, after the column has settled.
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (single_low) begin
            row_idx_d = row_idx_enc;
            pattern_d = row_sync_q;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        // Column stays frozen; any deviation from the latched pattern abandons the press.
        if (row_sync_q != pattern_q) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = ST_SCAN;
        end else if (cnt_q == DB_LAST) begin
          cnt_d       = '0;
          key_value_d = key_map(col_idx_q, row_idx_q);
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        // Any low row keeps us here, including other keys pressed meanwhile.
        cnt_d = '0;
        if (row_sync_q == 4'hF) begin
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (row_sync_q != 4'hF) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else if (cnt_q == DB_LAST) begin
          cnt_d      = '0;
          key_held_d = 1'b0;
          col_idx_d  = 2'd0;
          state_d    = ST_SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_SCAN;
      end
    endcase
  end

  assign key_value = key_value_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Directed bench for keypad_scanner with a small keypad matrix model.
module tb_keypad_scanner;

  localparam int CLK_FREQ    = 100_000;
  localparam int SCAN_HZ     = 1_000;
  localparam int DEBOUNCE_MS = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_held;

  // pressed[c*4+r] = key at column c, row r is physically down.
  logic [15:0] pressed = 16'h0000;

  int n_cmp = 0;
  int n_bad = 0;

  int         pulse_total = 0;
  int         double_cnt  = 0;
  int         kv_glitch   = 0;
  logic       prev_valid  = 1'b0;
  logic [3:0] prev_kv     = 4'h0;
  logic       rst_edge    = 1'b1;

  keypad_scanner #(
    .CLK_FREQ    (CLK_FREQ),
    .SCAN_HZ     (SCAN_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_value (key_value),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row reads low when a pressed key sits on a driven-low column.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[c*4+r] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) rst_edge <= rst;

  // Strobe monitor: counts pulses, back-to-back strobes, and value changes without a strobe.
  always @(negedge clk) begin
    if (key_valid) pulse_total <= pulse_total + 1;
    if (key_valid && prev_valid) double_cnt <= double_cnt + 1;
    if (!rst_edge && (key_value != prev_kv) && !key_valid) kv_glitch <= kv_glitch + 1;
    prev_valid <= key_valid;
    prev_kv    <= key_value;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (col == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (key_valid) break;
    end
  endtask

  task automatic wait_unheld(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!key_held) break;
    end
  endtask

  initial begin
    int n;
    bit ok;
    int base;

    // Reset state
    rst = 1'b1;
    tick(3);
    chk("rst_col",   32'(col), 32'(4'b1110));
    chk("rst_value", 32'(key_value), 32'(4'h0));
    chk("rst_valid", 32'(key_valid), 32'(1'b0));
    chk("rst_held",  32'(key_held), 32'(1'b0));
    rst = 1'b0;

    // 1: idle scan, 100 cycles per column
    base = pulse_total;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 99)  chk("t1_c0_last",  32'(col), 32'(4'b1110));
      if (i == 100) chk("t1_c1",       32'(col), 32'(4'b1101));
      if (i == 200) chk("t1_c2",       32'(col), 32'(4'b1011));
      if (i == 300) chk("t1_c3",       32'(col), 32'(4'b0111));
      if (i == 400) chk("t1_wrap",     32'(col), 32'(4'b1110));
    end
    chk("t1_no_valid", pulse_total - base, 0);

    // 2: key '5' (c1,r1), latency from column-1 start = 99 + 1 + 1000 = 1100
    base = pulse_total;
    pressed[5] = 1'b1;
    wait_col(4'b1101, 300, ok);
    chk("t2_reach_c1", 32'(ok), 1);
    wait_valid(2000, n);
    chk("t2_valid",   32'(key_valid), 32'(1'b1));
    chk("t2_latency", n, 1100);
    chk("t2_value",   32'(key_value), 32'(4'h5));
    tick(1);
    chk("t2_strobe_1cyc", 32'(key_valid), 32'(1'b0));
    chk("t2_held",        32'(key_held), 32'(1'b1));
    tick(699);
    pressed = 16'h0000;
    tick(1000);
    chk("t2_held_rel_1000", 32'(key_held), 32'(1'b1));
    tick(5);
    chk("t2_unheld_1005", 32'(key_held), 32'(1'b0));
    chk("t2_col_restart", 32'(col), 32'(4'b1110));
    chk("t2_one_pulse",   pulse_total - base, 1);

    // 3: key '9' (c2,r2) bouncing every 50 cycles, then stable
    base = pulse_total;
    for (int k = 0; k < 8; k++) begin
      pressed[10] = (k % 2 == 0);
      tick(50);
    end
    chk("t3_no_bounce_pulse", pulse_total - base, 0);
    pressed[10] = 1'b1;
    wait_valid(3000, n);
    chk("t3_valid", 32'(key_valid), 32'(1'b1));
    chk("t3_value", 32'(key_value), 32'(4'h9));
    tick(200);
    chk("t3_one_pulse", pulse_total - base, 1);
    pressed = 16'h0000;
    wait_unheld(1500);
    chk("t3_released", 32'(key_held), 32'(1'b0));

    // 4: '1' and '4' together on column 0 -> ignored, scan keeps moving
    base = pulse_total;
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    wait_col(4'b0111, 500, ok);
    chk("t4_scan_moves", 32'(ok), 1);
    tick(1200);
    chk("t4_no_valid", pulse_total - base, 0);
    chk("t4_not_held", 32'(key_held), 32'(1'b0));
    wait_col(4'b1110, 500, ok);
    chk("t4_scan_wraps", 32'(ok), 1);
    pressed = 16'h0000;

    // 5: hold 'A', add 'D', drop 'A' -> no second pulse; 'D' again after release
    base = pulse_total;
    pressed[12] = 1'b1;
    wait_valid(2000, n);
    chk("t5_valid_a", 32'(key_valid), 32'(1'b1));
    chk("t5_value_a", 32'(key_value), 32'(4'hA));
    tick(100);
    pressed[15] = 1'b1;
    tick(300);
    pressed[12] = 1'b0;
    tick(1500);
    chk("t5_no_second", pulse_total - base, 1);
    chk("t5_still_held", 32'(key_held), 32'(1'b1));
    chk("t5_value_kept", 32'(key_value), 32'(4'hA));
    pressed[15] = 1'b0;
    tick(1010);
    chk("t5_unheld", 32'(key_held), 32'(1'b0));
    chk("t5_no_pulse_rel", pulse_total - base, 1);
    pressed[15] = 1'b1;
    wait_valid(2000, n);
    chk("t5_valid_d", 32'(key_valid), 32'(1'b1));
    chk("t5_value_d", 32'(key_value), 32'(4'hD));
    pressed = 16'h0000;
    wait_unheld(1500);
    chk("t5_released", 32'(key_held), 32'(1'b0));

    // 6: reset during DEBOUNCE, then during HOLD, with key '2' (c1,r0)
    pressed[4] = 1'b1;
    wait_col(4'b1101, 300, ok);
    chk("t6_reach_c1", 32'(ok), 1);
    tick(600);
    chk("t6_col_frozen", 32'(col), 32'(4'b1101));
    rst = 1'b1;
    tick(1);
    chk("t6_db_rst_col",   32'(col), 32'(4'b1110));
    chk("t6_db_rst_held",  32'(key_held), 32'(1'b0));
    chk("t6_db_rst_valid", 32'(key_valid), 32'(1'b0));
    chk("t6_db_rst_value", 32'(key_value), 32'(4'h0));
    rst = 1'b0;
    wait_valid(2000, n);
    chk("t6_valid_2", 32'(key_valid), 32'(1'b1));
    chk("t6_value_2", 32'(key_value), 32'(4'h2));
    tick(50);
    chk("t6_held_2", 32'(key_held), 32'(1'b1));
    rst = 1'b1;
    tick(1);
    chk("t6_hold_rst_col",   32'(col), 32'(4'b1110));
    chk("t6_hold_rst_held",  32'(key_held), 32'(1'b0));
    chk("t6_hold_rst_valid", 32'(key_valid), 32'(1'b0));
    chk("t6_hold_rst_value", 32'(key_value), 32'(4'h0));
    rst = 1'b0;
    pressed = 16'h0000;
    tick(20);

    // Global strobe properties
    chk("no_double_valid",    double_cnt, 0);
    chk("kv_only_with_valid", kv_glitch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
